// File: rtl/noc_pkg.sv
// Shared NoC types for the binary-tree split and merge nodes.
package noc_pkg;

  localparam int PKT_W    = 9;
  localparam int ADDR_MSB = 8;
  localparam int ADDR_LSB = 5;

  typedef logic [PKT_W-1:0] pkt_t;

  typedef enum logic {
    SRC_0 = 1'b0,
    SRC_1 = 1'b1
  } src_t;

  // The input that gets priority after the given one has been granted.
  function automatic src_t other_src(input src_t s);
    return (s == SRC_0) ? SRC_1 : SRC_0;
  endfunction

endpackage

// File: rtl/arb_merge_node_if.sv
// Child-side and parent-side handshake bundle of the merge node.
interface arb_merge_node_if #(
  parameter int W = noc_pkg::PKT_W
);

  logic         in0_valid;
  logic [W-1:0] in0_data;
  logic         in0_ready;
  logic         in1_valid;
  logic [W-1:0] in1_data;
  logic         in1_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_src;
  logic         out_ready;

  // Node side: consumes child packets, produces the merged stream.
  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_src
  );

  // Environment side: the two children and the parent.
  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/merge_fifo.sv
// Small register-based input FIFO of the merge node. No fall-through:
// a pushed entry becomes visible at the head one cycle after the push.
module merge_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  output logic                   full_o,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CW'(1);
    end else if (!push_i && pop_i) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage array: data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  a_no_overflow  : assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o));

endmodule

// File: rtl/arb_merge_node.sv
// Two-into-one packet merge node: two input FIFOs, round-robin grant,
// one registered output stage tagged with the winning source.
module arb_merge_node
  import noc_pkg::*;
#(
  parameter int W     = PKT_W,
  parameter int DEPTH = 2
) (
  input logic              CLK,
  input logic              RESET,
  arb_merge_node_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          push0, push1, pop0, pop1;
  logic          full0, full1, empty0, empty1;
  logic [W-1:0]  head0, head1;
  logic [CW-1:0] cnt0, cnt1;

  logic          rdy_en_q;
  logic          load;
  logic          gnt_vld;
  src_t          gnt_src;

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  src_t          out_src_q,   out_src_d;
  src_t          rr_ptr_q,    rr_ptr_d;

  // Ready is held low through reset and for the first cycle after it.
  assign bus.in0_ready = rdy_en_q && (cnt0 < CW'(DEPTH));
  assign bus.in1_ready = rdy_en_q && (cnt1 < CW'(DEPTH));
  assign push0 = bus.in0_valid && bus.in0_ready;
  assign push1 = bus.in1_valid && bus.in1_ready;

  merge_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (CLK),
    .rst     (RESET),
    .push_i  (push0),
    .din_i   (bus.in0_data),
    .full_o  (full0),
    .pop_i   (pop0),
    .dout_o  (head0),
    .empty_o (empty0),
    .count_o (cnt0)
  );

  merge_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (CLK),
    .rst     (RESET),
    .push_i  (push1),
    .din_i   (bus.in1_data),
    .full_o  (full1),
    .pop_i   (pop1),
    .dout_o  (head1),
    .empty_o (empty1),
    .count_o (cnt1)
  );

  // Round-robin grant and next output-stage contents; only acts when the
  // output register is free or being drained this cycle.
  always_comb begin
    load    = !out_valid_q || bus.out_ready;
    gnt_vld = !empty0 || !empty1;
    if (!empty0 && !empty1) begin
      gnt_src = rr_ptr_q;
    end else if (!empty1) begin
      gnt_src = SRC_1;
    end else begin
      gnt_src = SRC_0;
    end
    pop0 = load && gnt_vld && (gnt_src == SRC_0);
    pop1 = load && gnt_vld && (gnt_src == SRC_1);

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = gnt_vld;
      if (gnt_vld) begin
        out_data_d = (gnt_src == SRC_1) ? head1 : head0;
        out_src_d  = gnt_src;
        rr_ptr_d   = other_src(gnt_src);
      end
    end
  end

  // Output register, round-robin pointer and post-reset ready enable.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rdy_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= SRC_0;
      rr_ptr_q    <= SRC_0;
    end else begin
      rdy_en_q    <= 1'b1;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

  a_push0_not_full : assert property (@(posedge CLK) disable iff (RESET) push0 |-> !full0);
  a_push1_not_full : assert property (@(posedge CLK) disable iff (RESET) push1 |-> !full1);
  a_stall_stable   : assert property (@(posedge CLK) disable iff (RESET)
                       (out_valid_q && !bus.out_ready) |=> ($stable(out_data_q) && $stable(out_src_q)));

endmodule

// File: tb/tb_arb_merge_node.sv
// Directed bench for the two-input merge node.
module tb_arb_merge_node;
  import noc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  pkt_t q0[$], q1[$];
  pkt_t sent0[$], sent1[$];
  pkt_t got_d[$];
  logic got_s[$];

  arb_merge_node_if #(.W(PKT_W)) bus ();

  arb_merge_node #(.W(PKT_W), .DEPTH(2)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    q0.delete(); q1.delete();
    sent0.delete(); sent1.delete();
    got_d.delete(); got_s.delete();
  endtask

  // One clock: offer queue heads, log any output transfer, advance on handshake.
  task automatic cycle(input bit v0, input bit v1, input logic ordy);
    bit f0, f1;
    bus.out_ready = ordy;
    bus.in0_valid = v0 && (q0.size() > 0);
    bus.in0_data  = (q0.size() > 0) ? q0[0] : '0;
    bus.in1_valid = v1 && (q1.size() > 0);
    bus.in1_data  = (q1.size() > 0) ? q1[0] : '0;
    f0 = bus.in0_valid && bus.in0_ready;
    f1 = bus.in1_valid && bus.in1_ready;
    if (bus.out_valid && ordy) begin
      got_d.push_back(bus.out_data);
      got_s.push_back(bus.out_src);
    end
    tick();
    if (f0) sent0.push_back(q0.pop_front());
    if (f1) sent1.push_back(q1.pop_front());
  endtask

  // Run until every queued packet has come out; bounded by limit cycles.
  task automatic drain(input string tag, input int limit, input bit toggle);
    bit   done;
    logic ordy;
    done = 1'b0;
    ordy = 1'b1;
    for (int c = 0; c < limit && !done; c++) begin
      cycle(1'b1, 1'b1, ordy);
      if (toggle) ordy = ~ordy;
      done = (q0.size() == 0) && (q1.size() == 0) && !bus.out_valid &&
             (got_d.size() == sent0.size() + sent1.size());
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  // Per-source order and completeness of everything logged so far.
  task automatic check_order(input string tag);
    pkt_t s0[$], s1[$];
    foreach (got_d[i]) begin
      if (got_s[i]) s1.push_back(got_d[i]);
      else          s0.push_back(got_d[i]);
    end
    check({tag, "_n0"}, 32'(s0.size()), 32'(sent0.size()));
    check({tag, "_n1"}, 32'(s1.size()), 32'(sent1.size()));
    for (int i = 0; i < s0.size() && i < sent0.size(); i++) check({tag, "_d0"}, 32'(s0[i]), 32'(sent0[i]));
    for (int i = 0; i < s1.size() && i < sent1.size(); i++) check({tag, "_d1"}, 32'(s1[i]), 32'(sent1[i]));
  endtask

  initial begin
    pkt_t exp3 [8];
    bus.in0_valid = 1'b0; bus.in0_data = '0;
    bus.in1_valid = 1'b0; bus.in1_data = '0;
    bus.out_ready = 1'b0;

    // Power-on reset state.
    tick(); tick();
    check("rst_in0_ready", 32'(bus.in0_ready), 32'd0);
    check("rst_in1_ready", 32'(bus.in1_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_src",   32'(bus.out_src),   32'd0);
    rst = 1'b0;
    check("rel_ready_low", 32'(bus.in0_ready), 32'd0);
    tick();
    check("rel_in0_ready", 32'(bus.in0_ready), 32'd1);
    check("rel_in1_ready", 32'(bus.in1_ready), 32'd1);

    // Single packet on in0: visible after the second edge, for one cycle.
    clear_logs();
    q0.push_back(9'h1A5);
    cycle(1, 0, 1);
    check("single_lat_t", 32'(bus.out_valid), 32'd0);
    cycle(0, 0, 1);
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_data",  32'(bus.out_data),  32'h1A5);
    check("single_src",   32'(bus.out_src),   32'd0);
    cycle(0, 0, 1);
    check("single_gone",  32'(bus.out_valid), 32'd0);

    // Single packet on in1 (also hands priority back to input 0).
    q1.push_back(9'h0C3);
    cycle(0, 1, 1);
    cycle(0, 0, 1);
    check("single1_valid", 32'(bus.out_valid), 32'd1);
    check("single1_data",  32'(bus.out_data),  32'h0C3);
    check("single1_src",   32'(bus.out_src),   32'd1);
    cycle(0, 0, 1);
    check("single1_gone",  32'(bus.out_valid), 32'd0);

    // Contention: four packets per input, strict alternation starting at 0.
    clear_logs();
    q0 = '{9'h101, 9'h102, 9'h103, 9'h104};
    q1 = '{9'h0E1, 9'h0E2, 9'h0E3, 9'h0E4};
    exp3 = '{9'h101, 9'h0E1, 9'h102, 9'h0E2, 9'h103, 9'h0E3, 9'h104, 9'h0E4};
    drain("cont", 60, 1'b0);
    check("cont_count", 32'(got_d.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      check("cont_src",  32'(got_s[i]), 32'(i % 2));
      check("cont_data", 32'(got_d[i]), 32'(exp3[i]));
    end

    // Backpressure: parent stalls for six cycles while both inputs stream.
    clear_logs();
    q0 = '{9'h111, 9'h112, 9'h113, 9'h114};
    q1 = '{9'h1E1, 9'h1E2, 9'h1E3, 9'h1E4};
    for (int c = 0; c < 6; c++) begin
      cycle(1, 1, 0);
      if (c >= 1) begin
        check("bp_hold_data", 32'(bus.out_data), 32'h111);
        check("bp_hold_src",  32'(bus.out_src),  32'd0);
      end
    end
    check("bp_valid",      32'(bus.out_valid), 32'd1);
    check("bp_in0_ready",  32'(bus.in0_ready), 32'd0);
    check("bp_in1_ready",  32'(bus.in1_ready), 32'd0);
    check("bp_accepted",   32'(sent0.size() + sent1.size()), 32'd5);
    drain("bp", 60, 1'b0);
    check("bp_first",  32'(got_d[0]), 32'h111);
    check("bp_second", 32'(got_d[1]), 32'h1E1);
    check_order("bp");

    // Wrap: twenty packets on in1 alone with the parent ready every other cycle.
    clear_logs();
    for (int i = 0; i < 20; i++) q1.push_back(pkt_t'(9'h140 + i));
    drain("wrap", 200, 1'b1);
    check("wrap_count", 32'(got_d.size()), 32'd20);
    for (int i = 0; i < 20 && i < got_d.size(); i++) begin
      check("wrap_data", 32'(got_d[i]), 32'(9'h140 + i));
      check("wrap_src",  32'(got_s[i]), 32'd1);
    end

    // Reset mid-burst with both FIFOs full and the output register loaded.
    clear_logs();
    q0 = '{9'h011, 9'h012, 9'h013, 9'h014};
    q1 = '{9'h0F1, 9'h0F2, 9'h0F3, 9'h0F4};
    for (int c = 0; c < 6; c++) cycle(1, 1, 0);
    check("mid_full_in0", 32'(bus.in0_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_in0_ready", 32'(bus.in0_ready), 32'd0);
    check("mid_rst_in1_ready", 32'(bus.in1_ready), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_data",  32'(bus.out_data),  32'd0);
    check("mid_rst_out_src",   32'(bus.out_src),   32'd0);
    clear_logs();
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_rel_ready_low", 32'(bus.in1_ready), 32'd0);
    tick();
    check("mid_rel_in0_ready", 32'(bus.in0_ready), 32'd1);
    check("mid_rel_in1_ready", 32'(bus.in1_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      cycle(0, 0, 1);
      check("mid_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // Random valid/ready traffic, then drain and compare against what was sent.
    clear_logs();
    for (int c = 0; c < 10000; c++) begin
      if (q0.size() == 0) q0.push_back(pkt_t'($urandom));
      if (q1.size() == 0) q1.push_back(pkt_t'($urandom));
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain("rand", 200, 1'b0);
    check_order("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
